// File: rtl/rw_mem_target.sv
// rw_mem_target
//   Emulated memory target behind the simulation server endpoints. Accepts one
//   192-bit read/write command at a time, executes it against an internal
//   array of DEPTH 64-bit words and returns exactly one 64-bit response.
//   After reset the whole array is swept to zero before commands are accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cmd_vld    command valid
//   cmd_rdy    command ready (high only in IDLE)
//   cmd        [63:0] opcode (0 write, 1 read), [127:64] address, [191:128] wdata
//   rsp_vld    response valid (high only in RESP)
//   rsp_rdy    response ready
//   rsp        registered response data, held after the handshake
//   busy       high in every state except IDLE
//   txn_count  completed response handshakes, wraps mod 2^32
//   err_count  commands answered with ERR_DATA, wraps mod 2^32
//
// state | meaning
// CLEAR | zeroing array[ptr], one word per cycle, DEPTH cycles total
// IDLE  | waiting for a command
// EXEC  | single cycle: access the array, register the response
// RESP  | holding the response until rsp_rdy
module rw_mem_target #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [63:0] ERR_DATA = 64'hDEAD_0000_0000_BAD0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  input  logic [191:0] cmd,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [63:0]  rsp,
  output logic         busy,
  output logic [31:0]  txn_count,
  output logic [31:0]  err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [63:0]   op_q, addr_q, wdata_q;
  logic [63:0]   rsp_q;
  logic [31:0]   txn_q, err_q;
  logic [63:0]   mem_q [DEPTH];

  logic          addr_ok, is_wr, is_rd, cmd_err, wr_en;
  logic [AW-1:0] idx;
  logic [63:0]   rd_data;

  // Range check uses the full 64-bit address so aliased high bits are rejected.
  always_comb begin
    addr_ok = (addr_q < 64'(DEPTH));
    is_wr   = (op_q == 64'd0);
    is_rd   = (op_q == 64'd1);
    cmd_err = !(addr_ok && (is_wr || is_rd));
    wr_en   = addr_ok && is_wr;
    idx     = addr_q[AW-1:0];
    rd_data = mem_q[idx];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (ptr_q == PTR_LAST) state_d = S_IDLE;
      S_IDLE:  if (cmd_vld)           state_d = S_EXEC;
      S_EXEC:                         state_d = S_RESP;
      S_RESP:  if (rsp_rdy)           state_d = S_IDLE;
      default:                        state_d = S_CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_rdy = (state_q == S_IDLE);
    rsp_vld = (state_q == S_RESP);
    busy    = (state_q != S_IDLE);
  end

  // Datapath: clear pointer, latched command, response and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      txn_q   <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: ptr_q <= ptr_q + AW'(1);
        S_IDLE: begin
          if (cmd_vld) begin
            op_q    <= cmd[63:0];
            addr_q  <= cmd[127:64];
            wdata_q <= cmd[191:128];
          end
        end
        S_EXEC: begin
          // rd_data is the pre-write contents, giving read-before-write on writes.
          rsp_q <= cmd_err ? ERR_DATA : rd_data;
          if (cmd_err) err_q <= err_q + 32'd1;
        end
        S_RESP: begin
          if (rsp_rdy) txn_q <= txn_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Array storage; cleared by the CLEAR sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR)
        mem_q[ptr_q] <= '0;
      else if (state_q == S_EXEC && wr_en)
        mem_q[idx] <= wdata_q;
    end
  end

  assign rsp       = rsp_q;
  assign txn_count = txn_q;
  assign err_count = err_q;

endmodule

// File: doc/rw_mem_target.md
Name: rw_mem_target

Overview:
- Server-side consumer of the read/write command stream that simulation clients push through the "rw_cmd" channel.
- Decodes each 192-bit command and executes it against an internal 64-bit-wide register array.
- Returns exactly one 64-bit response per command on the "rw_rsp" channel, which clients pull.
- Sits directly behind the multisim server endpoints, as the emulated DUT memory target.

Parameters:
- DEPTH, 16: number of 64-bit words in the array; must be a power of two, at least 2.
- ERR_DATA, 64'hDEAD_0000_0000_BAD0: response data returned for a bad opcode or an out-of-range address.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_vld  input  1  command valid.
- cmd_rdy  output  1  command ready.
- cmd  input  192  command word: [63:0] opcode (0 = write, 1 = read); [127:64] address; [191:128] wdata.
- rsp_vld  output  1  response valid.
- rsp_rdy  input  1  response ready.
- rsp  output  64  response data.
- busy  output  1  high in every state except IDLE.
- txn_count  output  32  count of completed response handshakes.
- err_count  output  32  count of commands that were answered with ERR_DATA.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - Next state is CLEAR; clear pointer = 0.
  - cmd_rdy = 0, rsp_vld = 0, rsp = 0, txn_count = 0, err_count = 0, busy = 1.
  - Reset applied in any state aborts that operation; a pending response is dropped.
- CLEAR:
  - Writes 0 to array[ptr] and increments ptr, one word per cycle.
  - Moves to IDLE after writing word DEPTH-1, so the sweep takes exactly DEPTH cycles.
  - cmd_rdy stays 0 throughout.
- IDLE:
  - cmd_rdy = 1 and busy = 0.
  - If cmd_vld is high at an edge, the command is latched into internal registers and the state goes to EXEC.
  - Nothing changes while cmd_vld is low.
- EXEC (one cycle; cmd_rdy = 0):
  - Address is in range when address < DEPTH, compared on the full 64 bits; the array is indexed by address[log2(DEPTH)-1:0].
  - Write, in range: array[addr] <= wdata; rsp <= previous contents of array[addr] (read-before-write).
  - Read, in range: rsp <= array[addr].
  - Any opcode other than 0 or 1, or any out-of-range address: no array update; rsp <= ERR_DATA; err_count increments.
  - At the same edge, rsp_vld <= 1 and the state goes to RESP.
- RESP:
  - rsp_vld and rsp are held stable until rsp_rdy is high at an edge.
  - At that edge: rsp_vld <= 0, txn_count increments, state goes to IDLE.
  - Holding rsp_rdy high early is allowed; the handshake completes on the first edge where rsp_vld is high.
- Latency:
  - Command accepted at edge k; rsp_vld is visible after edge k+1.
  - With rsp_rdy held high, the response handshake is at edge k+2 and cmd_rdy is high again after edge k+2.
  - Minimum command-to-command spacing is 3 cycles.
- Only one transaction is outstanding at a time; cmd_rdy is never high while rsp_vld is high.
- cmd_vld being high outside IDLE has no effect; the command is not consumed.
- Both counters wrap modulo 2^32 with no saturation.
- rsp is registered and holds its last value after the handshake.

Test Plan:
- Reset, then hold cmd_vld high -> cmd_rdy stays low for exactly 16 cycles after rst falls; a read of address 5 returns 0.
- Write 0xbebecacadeadb00b to address 3, then read address 3 -> the write response is 0; the read response is 0xbebecacadeadb00b; txn_count = 2.
- Write 0xdeadbeefcafedeca + a to addresses a = 0..9, then read 0..9 -> each read returns the matching value; a second write to address 0 returns 0xdeadbeefcafedeca.
- Read address 16, then issue opcode 2 to address 0 -> both responses equal ERR_DATA; err_count = 2; array contents unchanged.
- Hold rsp_rdy low for 5 cycles after rsp_vld rises -> rsp is stable, cmd_rdy stays low, and a new cmd_vld is not accepted; a single rsp_rdy pulse completes the transaction.
- Assert rst while in RESP -> rsp_vld drops at the next edge, the CLEAR sweep reruns, and both counters read 0.
